// File: rtl/tx_sched.sv
// Arbitrates the shared byte transmitter between the sample-dump (A) and
// command-readback (B) word sources, with XON/XOFF gating and a B-fairness burst cap.
module tx_sched #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int RDY_TMO   = 2
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             a_stb_i,
    input  logic [WIDTH-1:0] a_d_i,
    input  logic [2:0]       a_width_i,
    output logic             a_rdy_o,
    input  logic             b_stb_i,
    input  logic [WIDTH-1:0] b_d_i,
    input  logic [2:0]       b_width_i,
    output logic             b_rdy_o,
    input  logic             xon_i,
    input  logic             xoff_i,
    input  logic             tx_rdy_i,
    output logic             tx_stb_o,
    output logic [WIDTH-1:0] tx_o,
    output logic [2:0]       tx_width_o,
    output logic             paused_o,
    output logic             drop_o
);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW = (RDY_TMO > 1) ? $clog2(RDY_TMO) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;

    typedef struct packed {
        logic             full;
        logic [WIDTH-1:0] d;
        logic [2:0]       w;
    } slot_t;

    state_t        state;
    slot_t         slot_a, slot_b;
    logic [BW-1:0] burst;
    logic [TW-1:0] tmo;
    logic          gsel_b;
    logic          paused;
    logic          pick_b, can_grant;
    logic [2:0]    g_w;

    function automatic logic [2:0] sat_w(input logic [2:0] w);
        return (w > 3'd4) ? 3'd4 : w;
    endfunction

    assign pick_b    = slot_b.full &&
                       (!slot_a.full || (MAX_BURST != 0 && burst == BW'(MAX_BURST)));
    assign can_grant = (state == IDLE) && !paused && tx_rdy_i && (slot_a.full || slot_b.full);
    assign g_w       = pick_b ? slot_b.w : slot_a.w;

    assign a_rdy_o  = !slot_a.full;
    assign b_rdy_o  = !slot_b.full;
    assign paused_o = paused;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state      <= IDLE;
            slot_a     <= '0;
            slot_b     <= '0;
            burst      <= '0;
            tmo        <= '0;
            gsel_b     <= 1'b0;
            paused     <= 1'b0;
            tx_stb_o   <= 1'b0;
            tx_o       <= '0;
            tx_width_o <= '0;
            drop_o     <= 1'b0;
        end else begin
            tx_stb_o <= 1'b0;
            drop_o   <= 1'b0;

            if (xoff_i)
                paused <= 1'b1;
            else if (xon_i)
                paused <= 1'b0;

            // A slot never captures and frees in one cycle: capture needs it empty.
            if (a_stb_i && !slot_a.full)
                slot_a <= '{full: 1'b1, d: a_d_i, w: sat_w(a_width_i)};
            if (b_stb_i && !slot_b.full)
                slot_b <= '{full: 1'b1, d: b_d_i, w: sat_w(b_width_i)};

            if (can_grant && pick_b)
                burst <= '0;
            else if (!slot_b.full)
                burst <= '0;
            else if (can_grant && burst != BW'(MAX_BURST))
                burst <= burst + 1'b1;

            case (state)
                IDLE: begin
                    if (can_grant) begin
                        gsel_b <= pick_b;
                        if (g_w == 3'd0) begin
                            drop_o <= 1'b1;
                            if (pick_b) slot_b.full <= 1'b0;
                            else        slot_a.full <= 1'b0;
                        end else begin
                            tx_o       <= pick_b ? slot_b.d : slot_a.d;
                            tx_width_o <= g_w;
                            tx_stb_o   <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (gsel_b) slot_b.full <= 1'b0;
                    else        slot_a.full <= 1'b0;
                    tmo   <= '0;
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    // tx_rdy_i never dropping means the transmitter finished instantly.
                    if (!tx_rdy_i)
                        state <= WAIT_HI;
                    else if (tmo == TW'(RDY_TMO - 1))
                        state <= IDLE;
                    else
                        tmo <= tmo + 1'b1;
                end
                WAIT_HI: begin
                    if (tx_rdy_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: a MAX_BURST=4 instance plus a MAX_BURST=0 instance
// sharing clock, reset and transmitter-ready.
module tb_tx_sched;
    logic        clk_i = 1'b0;
    logic        rst_in;
    logic        a_stb_i, b_stb_i, xon_i, xoff_i, tx_rdy_i;
    logic [31:0] a_d_i, b_d_i;
    logic [2:0]  a_width_i, b_width_i;
    logic        a_rdy_o, b_rdy_o, tx_stb_o, paused_o, drop_o;
    logic [31:0] tx_o;
    logic [2:0]  tx_width_o;

    logic        z_a_stb, z_b_stb;
    logic [31:0] z_a_d, z_b_d;
    logic        z_a_rdy, z_b_rdy, z_tx_stb, z_paused, z_drop;
    logic [31:0] z_tx;
    logic [2:0]  z_tx_width;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] log_d[$];
    int          log_t[$];
    logic [31:0] zlog[$];

    int          fa_n = 0, fa_i = 0, za_n = 0, za_i = 0;
    logic [31:0] fa_base, za_base;
    bit          slow_tx = 1'b0;
    int          busy = 0;

    always #5 clk_i = ~clk_i;

    tx_sched #(.WIDTH(32), .MAX_BURST(4), .RDY_TMO(2)) dut (
        .clk_i(clk_i), .rst_in(rst_in),
        .a_stb_i(a_stb_i), .a_d_i(a_d_i), .a_width_i(a_width_i), .a_rdy_o(a_rdy_o),
        .b_stb_i(b_stb_i), .b_d_i(b_d_i), .b_width_i(b_width_i), .b_rdy_o(b_rdy_o),
        .xon_i(xon_i), .xoff_i(xoff_i), .tx_rdy_i(tx_rdy_i),
        .tx_stb_o(tx_stb_o), .tx_o(tx_o), .tx_width_o(tx_width_o),
        .paused_o(paused_o), .drop_o(drop_o)
    );

    tx_sched #(.WIDTH(32), .MAX_BURST(0), .RDY_TMO(2)) dut0 (
        .clk_i(clk_i), .rst_in(rst_in),
        .a_stb_i(z_a_stb), .a_d_i(z_a_d), .a_width_i(3'd1), .a_rdy_o(z_a_rdy),
        .b_stb_i(z_b_stb), .b_d_i(z_b_d), .b_width_i(3'd1), .b_rdy_o(z_b_rdy),
        .xon_i(1'b0), .xoff_i(1'b0), .tx_rdy_i(tx_rdy_i),
        .tx_stb_o(z_tx_stb), .tx_o(z_tx), .tx_width_o(z_tx_width),
        .paused_o(z_paused), .drop_o(z_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; afterwards outputs of the new cycle are visible. Also runs the
    // A feeders, the single-word B drops, the strobe logs and the transmitter model.
    task automatic tick();
        logic acc_a, acc_za, acc_b, acc_zb;
        acc_a  = a_stb_i && a_rdy_o;
        acc_za = z_a_stb && z_a_rdy;
        acc_b  = b_stb_i && b_rdy_o;
        acc_zb = z_b_stb && z_b_rdy;
        @(posedge clk_i);
        #1;
        cyc++;
        if (acc_a && fa_n > 0) begin
            fa_i++;
            if (fa_i >= fa_n) begin a_stb_i = 1'b0; fa_n = 0; end
            else a_d_i = fa_base + 32'(fa_i);
        end
        if (acc_za && za_n > 0) begin
            za_i++;
            if (za_i >= za_n) begin z_a_stb = 1'b0; za_n = 0; end
            else z_a_d = za_base + 32'(za_i);
        end
        if (acc_zb) z_b_stb = 1'b0;
        if (acc_b && fa_n > 0) b_stb_i = 1'b0;
        if (tx_stb_o) begin log_d.push_back(tx_o); log_t.push_back(cyc); end
        if (z_tx_stb) zlog.push_back(z_tx);
        if (busy > 0) begin
            busy--;
            if (busy == 0) tx_rdy_i = 1'b1;
        end
        if (slow_tx && tx_stb_o) begin busy = 3; tx_rdy_i = 1'b0; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        log_d.delete(); log_t.delete(); zlog.delete();
    endtask

    logic [31:0] exp1[7];
    logic [31:0] exp0[7];

    initial begin
        rst_in = 1'b0; a_stb_i = 0; b_stb_i = 0; xon_i = 0; xoff_i = 0; tx_rdy_i = 1'b1;
        a_d_i = 0; b_d_i = 0; a_width_i = 0; b_width_i = 0;
        z_a_stb = 0; z_b_stb = 0; z_a_d = 0; z_b_d = 0;
        ticks(3);
        chk("rst_a_rdy", a_rdy_o, 1);
        chk("rst_b_rdy", b_rdy_o, 1);
        chk("rst_stb", tx_stb_o, 0);
        chk("rst_tx", tx_o, 0);
        chk("rst_width", tx_width_o, 0);
        chk("rst_paused", paused_o, 0);
        chk("rst_drop", drop_o, 0);
        rst_in = 1'b1;
        tick();

        // Single A word: capture at n, strobe at n+2, slot ready at n+3.
        a_stb_i = 1; a_d_i = 32'hDEADBEEF; a_width_i = 3'd4;
        tick();
        a_stb_i = 0;
        chk("lat_a_rdy_n1", a_rdy_o, 0);
        chk("lat_stb_n1", tx_stb_o, 0);
        tick();
        chk("lat_stb_n2", tx_stb_o, 1);
        chk("lat_tx_n2", tx_o, 32'hDEADBEEF);
        chk("lat_width_n2", tx_width_o, 4);
        chk("lat_a_rdy_n2", a_rdy_o, 0);
        tick();
        chk("lat_a_rdy_n3", a_rdy_o, 1);
        chk("lat_stb_n3", tx_stb_o, 0);
        chk("lat_tx_hold", tx_o, 32'hDEADBEEF);
        ticks(4);

        // Simultaneous A and B with a slow transmitter.
        clear_logs();
        slow_tx = 1'b1;
        a_stb_i = 1; a_d_i = 32'h11; a_width_i = 3'd1;
        b_stb_i = 1; b_d_i = 32'h22; b_width_i = 3'd1;
        tick();
        a_stb_i = 0; b_stb_i = 0;
        ticks(15);
        chk("ab_count", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("ab_first", log_d[0], 32'h11);
            chk("ab_second", log_d[1], 32'h22);
            chk("ab_gap", log_t[1] - log_t[0], 5);
        end
        slow_tx = 1'b0;

        // Burst fairness: A refilled continuously, B holds 0x80, on both instances.
        clear_logs();
        a_width_i = 3'd1; b_width_i = 3'd1;
        fa_base = 32'hA0; fa_i = 0; fa_n = 6; a_d_i = 32'hA0; a_stb_i = 1;
        b_d_i = 32'h80; b_stb_i = 1;
        za_base = 32'hA0; za_i = 0; za_n = 6; z_a_d = 32'hA0; z_a_stb = 1;
        z_b_d = 32'h80; z_b_stb = 1;
        ticks(40);
        exp1 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h80, 32'hA4, 32'hA5};
        exp0 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'h80};
        chk("burst_count", log_d.size(), 7);
        chk("burst0_count", zlog.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_d.size()) chk($sformatf("burst_word%0d", i), log_d[i], exp1[i]);
            if (i < zlog.size())  chk($sformatf("burst0_word%0d", i), zlog[i], exp0[i]);
        end
        if (log_t.size() >= 2) chk("instant_period", log_t[1] - log_t[0], 4);
        fa_n = 0; za_n = 0; a_stb_i = 0; b_stb_i = 0; z_a_stb = 0; z_b_stb = 0;
        ticks(4);

        // XOFF in the same cycle B is captured holds the word back.
        clear_logs();
        b_stb_i = 1; b_d_i = 32'h55; b_width_i = 3'd2; xoff_i = 1;
        tick();
        b_stb_i = 0; xoff_i = 0;
        ticks(50);
        chk("xoff_no_stb", log_d.size(), 0);
        chk("xoff_paused", paused_o, 1);
        chk("xoff_b_full", b_rdy_o, 0);
        xon_i = 1;
        tick();
        xon_i = 0;
        chk("xon_paused", paused_o, 0);
        chk("xon_stb_early", tx_stb_o, 0);
        tick();
        chk("xon_stb", tx_stb_o, 1);
        chk("xon_tx", tx_o, 32'h55);
        ticks(4);
        xon_i = 1; xoff_i = 1;
        tick();
        xon_i = 0; xoff_i = 0;
        chk("both_paused", paused_o, 1);
        xon_i = 1;
        tick();
        xon_i = 0;
        chk("resume_paused", paused_o, 0);

        // Width 0 is dropped, width 6 saturates to 4.
        clear_logs();
        a_stb_i = 1; a_d_i = 32'h77; a_width_i = 3'd0;
        tick();
        a_stb_i = 0;
        chk("w0_a_rdy_n1", a_rdy_o, 0);
        tick();
        chk("w0_drop", drop_o, 1);
        chk("w0_a_rdy", a_rdy_o, 1);
        chk("w0_no_stb", tx_stb_o, 0);
        tick();
        chk("w0_drop_end", drop_o, 0);
        chk("w0_log", log_d.size(), 0);
        a_stb_i = 1; a_d_i = 32'h66; a_width_i = 3'd6;
        tick();
        a_stb_i = 0;
        tick();
        chk("w6_stb", tx_stb_o, 1);
        chk("w6_width", tx_width_o, 4);
        chk("w6_tx", tx_o, 32'h66);
        ticks(4);

        // Reset while waiting for the transmitter with B still held.
        clear_logs();
        slow_tx = 1'b1;
        a_stb_i = 1; a_d_i = 32'h31; a_width_i = 3'd2;
        b_stb_i = 1; b_d_i = 32'h32; b_width_i = 3'd2;
        tick();
        a_stb_i = 0; b_stb_i = 0;
        tick();
        chk("rw_stb", tx_stb_o, 1);
        chk("rw_tx", tx_o, 32'h31);
        ticks(2);
        chk("rw_b_full", b_rdy_o, 0);
        rst_in = 1'b0;
        tick();
        chk("rw_a_rdy", a_rdy_o, 1);
        chk("rw_b_rdy", b_rdy_o, 1);
        chk("rw_stb0", tx_stb_o, 0);
        chk("rw_tx0", tx_o, 0);
        chk("rw_width0", tx_width_o, 0);
        chk("rw_paused0", paused_o, 0);
        chk("rw_drop0", drop_o, 0);
        rst_in = 1'b1; slow_tx = 1'b0; busy = 0; tx_rdy_i = 1'b1;
        clear_logs();
        ticks(10);
        chk("rw_no_stb", log_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
